keycode_event_queue: RTL
========================

KEYCODE_EVENT_QUEUE -- requirements
Module: keycode_event_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, minimum 2).
REQ-002 SHALL have parameter REPEAT_DELAY, default 24'd5_000_000, clk cycles before the first auto-repeat.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 24'd1_500_000, clk cycles between auto-repeats.
REQ-004 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous, active-low reset.
REQ-006 SHALL have port keycode, input, 8, current keycode from the keycode PIO output port (8'h00 = no key).
REQ-007 SHALL have port evt_ready, input, 1, consumer accepts the head event.
REQ-008 SHALL have port ovf_clr, input, 1, clears the overflow flag.
REQ-009 SHALL have port evt_valid, output, 1, FIFO non-empty.
REQ-010 SHALL have port evt_code, output, 8, keycode of the head event.
REQ-011 SHALL have port evt_press, output, 1, 1 = press, 0 = release.
REQ-012 SHALL have port evt_repeat, output, 1, head event is an auto-repeat press.
REQ-013 SHALL have port evt_count, output, $clog2(DEPTH)+1, FIFO occupancy.
REQ-014 SHALL have port overflow, output, 1, sticky flag: an event was dropped.

Function
REQ-015 SHALL register keycode into kc_q every cycle; the FSM compares only kc_q against the committed register.
REQ-016 FSM SHALL have states IDLE, REL, PRESS.
REQ-017 In IDLE with kc_q != committed: SHALL latch pending = kc_q; go to REL if committed != 0, else to PRESS.
REQ-018 REL SHALL push {committed, press=0, repeat=0}; if pending == 0, committed <= 0 and go to IDLE, else go to PRESS.
REQ-019 PRESS SHALL push {pending, press=1, repeat=0}, set committed <= pending, and go to IDLE.
REQ-020 Latency: keycode change at edge k SHALL make its first event visible on evt_* after edge k+2 with an empty FIFO; the press of a key-to-key change SHALL follow one cycle later.
REQ-021 Changes of keycode while the FSM is in REL/PRESS SHALL NOT be queued individually; they SHALL be re-evaluated on return to IDLE, so only the final code produces events.
REQ-022 Pop SHALL occur when evt_valid && evt_ready; evt_* SHALL show the head entry combinationally from FIFO storage (no fall-through from push).
REQ-023 Push to a full FIFO without a same-cycle pop SHALL drop the event, set overflow, and leave the FSM advancing normally (no stall).
REQ-024 Push and pop in the same cycle when full SHALL accept the push; count SHALL be unchanged.
REQ-025 Pop when empty SHALL be ignored.
REQ-026 overflow SHALL clear on ovf_clr; a drop in the same cycle as ovf_clr SHALL take priority (overflow stays 1).
REQ-027 Read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-028 reset_n low SHALL asynchronously force kc_q = 0, committed = 0, pending = 0, state = IDLE, pointers = 0, evt_count = 0, evt_valid = 0, overflow = 0, and the repeat counter = 0.
REQ-029 Reset mid-sequence SHALL discard queued and in-progress events; after release, a held nonzero keycode SHALL produce exactly one press.

Configuration
REQ-030 With KEYCODE_EVENT_TYPEMATIC_EN defined, in IDLE with committed != 0 and kc_q == committed, a counter SHALL push {committed, 1, repeat=1} after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles; any change or leaving IDLE SHALL zero the counter.
REQ-031 Without KEYCODE_EVENT_TYPEMATIC_EN, no repeat counter SHALL exist and evt_repeat SHALL be constant 0.

Structure
REQ-032 Package keycode_pkg SHALL hold KEY_NONE = 8'h00, the typedef key_event_t {code[7:0], press, repeat}, and the FSM state enum.
REQ-033 Storage SHALL be one sub-module kev_fifo (parameter DEPTH, push/pop, key_event_t data, count, full/empty).

Verification
REQ-034 Bench SHALL cover: keycode 00 -> 1A -> single press 1A; valid high 3 edges after the change; count = 1.
REQ-035 Bench SHALL cover: 1A -> 04 with evt_ready = 1 -> release 1A, then press 04 in consecutive cycles.
REQ-036 Bench SHALL cover: evt_ready = 0 with 5 key changes at DEPTH = 8 -> count = 8, overflow = 1 after the 9th push, head still the first event; ovf_clr -> overflow = 0.
REQ-037 Bench SHALL cover: keycode 1A -> 2B -> 3C on consecutive cycles -> events press 1A, release 1A, press 3C only.
REQ-038 Bench SHALL cover: reset_n pulsed while in REL with 3 queued -> count = 0, evt_valid = 0; held 04 -> one press 04.
REQ-039 Bench SHALL cover, with TYPEMATIC_EN, REPEAT_DELAY = 10, REPEAT_PERIOD = 4, key 1A held 30 cycles -> repeat presses at about 10, 14, 18, 22, 26 cycles after the press.

Source files
------------

// File: rtl/keycode_pkg.sv
// keycode_pkg: shared types for the keycode event queue.
// Holds the "no key" code, the queued event record and the FSM state type.
package keycode_pkg;

  localparam logic [7:0] KEY_NONE = 8'h00;

  // One queued event; is_repeat marks an auto-repeat press.
  typedef struct packed {
    logic [7:0] code;
    logic       press;
    logic       is_repeat;
  } key_event_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REL   = 2'd1,
    ST_PRESS = 2'd2
  } kev_state_t;

  function automatic key_event_t make_event(input logic [7:0] code,
                                            input logic       press,
                                            input logic       is_repeat);
    key_event_t e;
    e.code      = code;
    e.press     = press;
    e.is_repeat = is_repeat;
    return e;
  endfunction

endpackage

// File: rtl/kev_fifo.sv
// kev_fifo: DEPTH-entry FIFO of key events (DEPTH a power of two, >= 2).
// Handshake: a push is taken when i_push is high and the FIFO is not full, or
// when it is full but a pop happens in the same cycle; a pop is taken when
// i_pop is high and the FIFO is not empty, otherwise it is ignored.
// o_head shows the stored head entry; a push never falls through to o_head
// in the cycle it is written.
module kev_fifo
  import keycode_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_push,
  input  key_event_t    i_data,
  input  logic          i_pop,
  output key_event_t    o_head,
  output logic [AW:0]   o_count,
  output logic          o_full,
  output logic          o_empty
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  key_event_t    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_CNT);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage write; contents need no reset since the count gates visibility.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks net pushes minus pops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/keycode_event_queue.sv
// keycode_event_queue: turns a sampled keycode level into press/release
// events held in a small FIFO for a consumer.
// Optional auto-repeat is built when KEYCODE_EVENT_TYPEMATIC_EN is defined.
// Consumer handshake: an event is taken on a rising edge where evt_valid and
// evt_ready are both high; evt_* show the head entry until it is taken.
module keycode_event_queue
  import keycode_pkg::*;
#(
  parameter int          DEPTH         = 8,
  parameter logic [23:0] REPEAT_DELAY  = 24'd5_000_000,
  parameter logic [23:0] REPEAT_PERIOD = 24'd1_500_000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [7:0]               keycode,
  input  logic                     evt_ready,
  input  logic                     ovf_clr,
  output logic                     evt_valid,
  output logic [7:0]               evt_code,
  output logic                     evt_press,
  output logic                     evt_repeat,
  output logic [$clog2(DEPTH):0]   evt_count,
  output logic                     overflow,
  output kev_state_t               dbg_state
);

  logic [7:0] r_kc_q;
  logic [7:0] r_committed;
  logic [7:0] r_pending;
  kev_state_t r_state;
  logic       r_ovf;

  logic       w_push;
  key_event_t w_push_evt;
  key_event_t w_head;
  logic       w_full;
  logic       w_empty;
  logic       w_drop;
  logic       w_rep_fire;

  // Sample the keycode once; the FSM only ever looks at this copy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_kc_q <= KEY_NONE;
    else          r_kc_q <= keycode;
  end

  // Change detector: release the old code (if any), then press the new one.
  // Codes seen while in REL/PRESS are picked up again once back in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_committed <= KEY_NONE;
      r_pending   <= KEY_NONE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_kc_q != r_committed) begin
            r_pending <= r_kc_q;
            r_state   <= (r_committed != KEY_NONE) ? ST_REL : ST_PRESS;
          end
        end
        ST_REL: begin
          if (r_pending == KEY_NONE) begin
            r_committed <= KEY_NONE;
            r_state     <= ST_IDLE;
          end else begin
            r_state <= ST_PRESS;
          end
        end
        ST_PRESS: begin
          r_committed <= r_pending;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef KEYCODE_EVENT_TYPEMATIC_EN
  logic [23:0] r_rep_cnt;
  logic        r_rep_armed;
  logic        w_rep_hold;
  logic [23:0] w_rep_limit;

  assign w_rep_hold  = (r_state == ST_IDLE) && (r_committed != KEY_NONE) &&
                       (r_kc_q == r_committed);
  assign w_rep_limit = r_rep_armed ? REPEAT_PERIOD : REPEAT_DELAY;
  assign w_rep_fire  = w_rep_hold && (r_rep_cnt == w_rep_limit - 24'd1);

  // Typematic timer: first repeat after REPEAT_DELAY, then every REPEAT_PERIOD.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b0;
    end else if (!w_rep_hold) begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b0;
    end else if (w_rep_fire) begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b1;
    end else begin
      r_rep_cnt <= r_rep_cnt + 24'd1;
    end
  end

  assign evt_repeat = w_head.is_repeat;
`else
  logic w_unused_cfg;
  assign w_rep_fire   = 1'b0;
  assign evt_repeat   = 1'b0;
  assign w_unused_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD, w_head.is_repeat};
`endif

  // Push source: REL/PRESS states, or a repeat tick while idle and held.
  always_comb begin
    w_push     = 1'b0;
    w_push_evt = make_event(KEY_NONE, 1'b0, 1'b0);
    case (r_state)
      ST_REL: begin
        w_push     = 1'b1;
        w_push_evt = make_event(r_committed, 1'b0, 1'b0);
      end
      ST_PRESS: begin
        w_push     = 1'b1;
        w_push_evt = make_event(r_pending, 1'b1, 1'b0);
      end
      default: begin
        if (w_rep_fire) begin
          w_push     = 1'b1;
          w_push_evt = make_event(r_committed, 1'b1, 1'b1);
        end
      end
    endcase
  end

  kev_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  (w_push_evt),
    .i_pop   (evt_ready),
    .o_head  (w_head),
    .o_count (evt_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A full FIFO is never empty, so a pop that cycle means evt_ready alone.
  assign w_drop = w_push && w_full && !evt_ready;

  // Sticky overflow; a drop wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (ovf_clr) r_ovf <= 1'b0;
  end

  assign evt_valid = !w_empty;
  assign evt_code  = w_head.code;
  assign evt_press = w_head.press;
  assign overflow  = r_ovf;
  assign dbg_state = r_state;

endmodule
